// File: rtl/cpu_dbg_pkg.sv
// Purpose: shared types and constants for the end-of-run register dump streamer.
// Latency: n/a (types, constants and a header-packing helper only).
// Backpressure: n/a.
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_SEL  = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int FRAME_WORDS = 34;
  localparam int HDR_WORDS   = 2;

  localparam logic [1:0] RSN_NONE  = 2'b00;
  localparam logic [1:0] RSN_LIMIT = 2'b01;
  localparam logic [1:0] RSN_STALL = 2'b10;
  localparam logic [1:0] RSN_BOTH  = 2'b11;

  // Header word layout: stop reason in the top two bits, cycle count in the low half.
  localparam int HDR_RSN_LSB = 30;
  localparam int HDR_RSN_W   = 2;
  localparam int HDR_CNT_LSB = 0;
  localparam int HDR_CNT_W   = 16;

  function automatic logic [31:0] build_hdr(input logic [1:0] rsn, input logic [15:0] cnt);
    logic [31:0] w;
    w = '0;
    w[HDR_RSN_LSB +: HDR_RSN_W] = rsn;
    w[HDR_CNT_LSB +: HDR_CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/pc_stall_detector.sv
// Purpose: flags a halted CPU once the PC has stayed unchanged for STALL_LIMIT consecutive cycles.
// Latency: stall is combinational from pc and the registered last_pc/stall_cnt.
// Backpressure: none; clr reloads last_pc from pc and zeroes the count.
module pc_stall_detector #(
  parameter int STALL_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] pc,
  output logic        stall
);

  localparam int CW = $clog2(STALL_LIMIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(STALL_LIMIT - 1);

  logic [31:0]   last_pc;
  logic [CW-1:0] stall_cnt;
  logic          same_pc;

  assign same_pc = (pc == last_pc);
  // The current unchanged cycle is the final one of the run of STALL_LIMIT.
  assign stall   = run && same_pc && (stall_cnt == CNT_MAX);

  // Track the last distinct PC and how many cycles it has been repeated.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc   <= '0;
      stall_cnt <= '0;
    end else if (clr) begin
      last_pc   <= pc;
      stall_cnt <= '0;
    end else if (run) begin
      if (!same_pc) begin
        last_pc   <= pc;
        stall_cnt <= '0;
      end else if (stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_dump_streamer.sv
// Purpose: detects end of program run, then streams a 34-word frame (header, PC, x0..x31).
// Latency: first word valid 2 cycles after the stop cycle; 1 word per 2 cycles at full ready.
// Backpressure: m_valid/m_data/m_last held until m_ready; m_valid never depends on m_ready.
module reg_dump_streamer
  import cpu_dbg_pkg::*;
#(
  parameter int CYCLE_LIMIT = 100,
  parameter int STALL_LIMIT = 8,
  parameter int NREGS       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] pc,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        done,
  output logic [1:0]  stop_rsn
);

  localparam int LAST_WORD = HDR_WORDS + NREGS - 1;

  state_t      state, state_nxt;
  logic [15:0] cyc_cnt;
  logic [15:0] cyc_inc;
  logic [15:0] final_cnt;
  logic [31:0] final_pc;
  logic [5:0]  idx;
  logic [5:0]  idx_inc;
  logic [4:0]  sel_nxt;
  logic [31:0] word_dat;
  logic        stall;
  logic        limit_hit;
  logic        stop_hit;
  logic        accept;
  logic        det_clr;
  logic        det_run;

  assign det_clr   = (state == ST_IDLE);
  assign det_run   = (state == ST_RUN) && en;
  assign cyc_inc   = (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;
  assign limit_hit = (cyc_cnt == 16'(CYCLE_LIMIT - 1));
  assign stop_hit  = det_run && (limit_hit || stall);
  assign accept    = (state == ST_SEND) && m_valid && m_ready;
  assign idx_inc   = idx + 6'd1;
  // Header words leave the regfile select parked at x0.
  assign sel_nxt   = (idx_inc >= 6'(HDR_WORDS)) ? 5'(idx_inc - 6'(HDR_WORDS)) : 5'd0;

  pc_stall_detector #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall (
    .clk  (clk),
    .rst  (rst),
    .clr  (det_clr),
    .run  (det_run),
    .pc   (pc),
    .stall(stall)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; an en drop in RUN abandons the run without emitting anything.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en) state_nxt = ST_RUN;
      ST_RUN: begin
        if (!en)          state_nxt = ST_IDLE;
        else if (stop_hit) state_nxt = ST_SEL;
      end
      ST_SEL:  state_nxt = ST_SEND;
      ST_SEND: begin
        if (accept) state_nxt = (idx == 6'(LAST_WORD)) ? ST_DONE : ST_SEL;
      end
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Select the word to load: header, final PC, x0 forced to zero, else regfile data.
  always_comb begin
    word_dat = reg_data;
    if (idx == 6'd0)                word_dat = build_hdr(stop_rsn, final_cnt);
    else if (idx == 6'd1)           word_dat = final_pc;
    else if (idx == 6'(HDR_WORDS))  word_dat = '0;
  end

  // Run counters, stop capture, word index and the registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt   <= '0;
      final_cnt <= '0;
      final_pc  <= '0;
      idx       <= '0;
      reg_sel   <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      done      <= 1'b0;
      stop_rsn  <= RSN_NONE;
    end else begin
      case (state)
        ST_IDLE: cyc_cnt <= '0;
        ST_RUN: begin
          if (!en) begin
            cyc_cnt <= '0;
          end else if (stop_hit) begin
            stop_rsn  <= (stall && limit_hit) ? RSN_BOTH :
                         stall                ? RSN_STALL : RSN_LIMIT;
            final_pc  <= pc;
            final_cnt <= cyc_inc;
            idx       <= '0;
            reg_sel   <= '0;
          end else begin
            cyc_cnt <= cyc_inc;
          end
        end
        ST_SEL: begin
          m_data  <= word_dat;
          m_last  <= (idx == 6'(LAST_WORD));
          m_valid <= 1'b1;
        end
        ST_SEND: begin
          if (accept) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (idx == 6'(LAST_WORD)) begin
              done <= 1'b1;
            end else begin
              idx     <= idx_inc;
              reg_sel <= sel_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Purpose: self-checking bench for reg_dump_streamer (stop detection, frame content, flow control).
// Latency: checks first-word latency and full-rate frame duration.
// Backpressure: drives random m_ready and checks held words stay stable.
module tb_reg_dump_streamer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] pc;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        done;
  logic [1:0]  stop_rsn;

  int n_checks = 0;
  int n_errs   = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
  int words_seen = 0;

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
    logic [4:0]  sel;
  } exp_t;

  typedef struct {
    logic [31:0] base;
    int          hold_k;
    int          stop_k;
    bit          rnd;
    logic [1:0]  rsn;
    logic [15:0] cnt;
    logic [31:0] fpc;
    int          cyc;
  } case_t;

  exp_t  sb[$];
  case_t cases[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model: xN = N*0x11111111, x0 reads back garbage that must be masked.
  assign reg_data = (reg_sel == 5'd0) ? 32'hDEAD_BEEF : 32'(reg_sel) * 32'h1111_1111;

  reg_dump_streamer #(
    .CYCLE_LIMIT(100),
    .STALL_LIMIT(8),
    .NREGS(32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .pc      (pc),
    .reg_sel (reg_sel),
    .reg_data(reg_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .done    (done),
    .stop_rsn(stop_rsn)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pc_of(input case_t c, input int k);
    int kk;
    kk = (k < c.hold_k) ? k : c.hold_k;
    return c.base + 32'(4 * kk);
  endfunction

  function automatic exp_t exp_word(input case_t c, input int n);
    exp_t e;
    e.last = (n == 33);
    e.sel  = (n >= 2) ? 5'(n - 2) : 5'd0;
    if (n == 0)      e.dat = {c.rsn, 14'b0, c.cnt};
    else if (n == 1) e.dat = c.fpc;
    else if (n == 2) e.dat = 32'h0;
    else             e.dat = 32'(n - 2) * 32'h1111_1111;
    return e;
  endfunction

  // Ready driver, updated after the main thread's input changes in each cycle.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Stream monitor: scoreboard pop on accept, stability check while stalled.
  initial begin
    logic        prev_hold;
    logic [31:0] prev_dat;
    logic        prev_last;
    exp_t        e;
    prev_hold = 1'b0;
    prev_dat  = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold)
          check("hold_stable", 64'({m_valid, m_last, m_data}), 64'({1'b1, prev_last, prev_dat}));
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL extra_word: got word %0d with data %h expected none", words_seen, m_data);
          end else begin
            e = sb.pop_front();
            check($sformatf("word%0d", words_seen),
                  64'({m_data, m_last, reg_sel}), 64'({e.dat, e.last, e.sel}));
          end
          words_seen++;
        end
        prev_hold = m_valid && !m_ready;
        prev_dat  = m_data;
        prev_last = m_last;
      end
    end
  end

  task automatic start_case(input case_t c, input int id);
    rdy_mode = 0;
    en  = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check($sformatf("c%0d_reset", id),
          64'({reg_sel, m_valid, m_data, m_last, done, stop_rsn}), 64'(0));
    sb.delete();
    words_seen = 0;
    for (int n = 0; n < 34; n++) sb.push_back(exp_word(c, n));
    rdy_mode = c.rnd ? 1 : 0;
    pc = pc_of(c, -1);
    en = 1'b1;
    step();
    for (int k = 0; k <= c.stop_k; k++) begin
      pc = pc_of(c, k);
      if (k == c.stop_k)
        check($sformatf("c%0d_prestop", id), 64'({m_valid, stop_rsn}), 64'(0));
      step();
    end
    en = 1'b0;
    pc = 32'h1234_5678;
    check($sformatf("c%0d_sel_cycle", id), 64'(m_valid), 64'(0));
    step();
    check($sformatf("c%0d_first_valid", id), 64'({m_valid, stop_rsn}), 64'({1'b1, c.rsn}));
  endtask

  task automatic finish_case(input case_t c, input int id);
    int waited;
    waited = 0;
    while (!done && waited < 500) begin
      step();
      waited++;
    end
    check($sformatf("c%0d_done", id), 64'(done), 64'(1));
    if (c.cyc != 0)
      check($sformatf("c%0d_frame_cycles", id), 64'(waited), 64'(c.cyc));
    check($sformatf("c%0d_end_state", id), 64'({sb.size(), reg_sel, m_valid}), 64'({32'd0, 5'd31, 1'b0}));
  endtask

  initial begin
    int waited;
    int bad;
    rst = 1'b1;
    en  = 1'b0;
    pc  = '0;

    // base, hold_k, stop_k, rnd, rsn, cnt, final pc, frame cycles at full ready
    cases[0] = '{32'h4,  100000, 99, 1'b0, 2'b01, 16'd100, 32'h0000_0190, 67};
    cases[1] = '{32'h18, 18,     26, 1'b1, 2'b10, 16'd27,  32'h0000_0060, 0};
    cases[2] = '{32'h4,  91,     99, 1'b0, 2'b11, 16'd100, 32'h0000_0170, 67};

    for (int i = 0; i < 3; i++) begin
      start_case(cases[i], i);
      finish_case(cases[i], i);
    end

    // Reset while word 10 is being offered, then a full clean rerun.
    start_case(cases[0], 3);
    waited = 0;
    while (words_seen < 10 && waited < 200) begin
      step();
      waited++;
    end
    rdy_mode = 2;
    step();
    check("t6_w10_pending", 64'({m_valid, 32'(words_seen)}), 64'({1'b1, 32'd10}));
    rst = 1'b1;
    step();
    check("t6_reset_outputs", 64'({reg_sel, m_valid, m_data, m_last, done, stop_rsn}), 64'(0));
    rst = 1'b0;
    sb.delete();
    start_case(cases[0], 4);
    finish_case(cases[0], 4);

    // en dropped mid-run: back to IDLE, nothing emitted even with a stuck PC.
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    words_seen = 0;
    bad = 0;
    pc = 32'h0;
    en = 1'b1;
    step();
    for (int k = 0; k < 50; k++) begin
      pc = 32'(4 * k + 4);
      step();
      if (m_valid) bad++;
    end
    en = 1'b0;
    pc = 32'h200;
    for (int k = 0; k < 150; k++) begin
      step();
      if (m_valid) bad++;
    end
    check("en_drop_no_valid", 64'(bad), 64'(0));
    check("en_drop_idle_outputs", 64'({stop_rsn, done, 32'(words_seen)}), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
